// File: rtl/dmux16_stream.sv
// One-to-two word demultiplexer. Each sink has a one-entry output register
// and its own valid/ready handshake, so a stalled sink never blocks the other.
module dmux16_stream #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] x_data,
  output logic             x_valid,
  input  logic             x_ready,
  output logic [WIDTH-1:0] y_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [CNT_W-1:0] x_cnt,
  output logic [CNT_W-1:0] y_cnt
);

  logic x_room;
  logic y_room;
  logic acc_x;
  logic acc_y;

  // A sink has room when empty or being drained this cycle.
  always_comb begin
    x_room   = !x_valid || x_ready;
    y_room   = !y_valid || y_ready;
    in_ready = rst_n && !flush && (in_sel ? y_room : x_room);
    acc_x    = in_valid && in_ready && !in_sel;
    acc_y    = in_valid && in_ready && in_sel;
  end

  // Sink X register, valid flag and accept counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_data  <= '0;
      x_valid <= 1'b0;
      x_cnt   <= '0;
    end else if (flush) begin
      x_valid <= 1'b0;
    end else if (acc_x) begin
      x_data  <= in_data;
      x_valid <= 1'b1;
      x_cnt   <= x_cnt + CNT_W'(1);
    end else if (x_valid && x_ready) begin
      x_valid <= 1'b0;
    end
  end

  // Sink Y register, valid flag and accept counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_data  <= '0;
      y_valid <= 1'b0;
      y_cnt   <= '0;
    end else if (flush) begin
      y_valid <= 1'b0;
    end else if (acc_y) begin
      y_data  <= in_data;
      y_valid <= 1'b1;
      y_cnt   <= y_cnt + CNT_W'(1);
    end else if (y_valid && y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: doc/dmux16_stream.md
# dmux16_stream

16-bit one-to-two demultiplexing stage for the HACK datapath: the write-side counterpart of the two-input word selector. It accepts one word per cycle from a single producer and routes it, by a select bit, to one of two registered sink ports (X for sel=0, Y for sel=1). Each sink has its own one-entry output register and valid/ready handshake, so a stalled sink never blocks traffic to the other. Used to steer ALU results and load data towards the A/D register paths and memory-write paths.

## Interface

Parameters:
- WIDTH, 16, data word width
- CNT_W, 8, width of per-sink accepted-word counters

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  word from producer
- in_sel  input  1  destination: 0 = X, 1 = Y; qualified by in_valid
- in_valid  input  1  producer has a word
- in_ready  output  1  stage accepts the word this cycle
- flush  input  1  synchronous discard of both output registers
- x_data  output  WIDTH  word for sink X
- x_valid  output  1  x_data holds an undelivered word
- x_ready  input  1  sink X takes x_data this cycle
- y_data  output  WIDTH  word for sink Y
- y_valid  output  1  y_data holds an undelivered word
- y_ready  input  1  sink Y takes y_data this cycle
- x_cnt  output  CNT_W  words accepted for X since reset, wraps
- y_cnt  output  CNT_W  words accepted for Y since reset, wraps

## Operation

- Reset (rst_n low, asynchronous): x_valid=0, y_valid=0, x_data=0, y_data=0, x_cnt=0, y_cnt=0. in_ready is combinational and is 0 while rst_n is low.
- in_ready = !flush && (in_sel ? (!y_valid || y_ready) : (!x_valid || x_ready)). It depends combinationally on in_sel, flush, and the selected sink's valid/ready only; the unselected sink never affects it.
- Accept = in_valid && in_ready. On accept with in_sel=0: x_data <= in_data, x_valid <= 1, x_cnt <= x_cnt+1. With in_sel=1: the same for Y.
- Per sink, when x_valid && x_ready and no new accept targets X: x_valid <= 0. x_data holds its last value.
- Simultaneous drain and accept on the same sink: the new word is loaded, x_valid stays 1, and throughput is one word per cycle.
- While x_valid && !x_ready, x_data is held stable and is not overwritten.
- The unselected sink's registers are untouched by an accept.
- flush=1: on the next edge x_valid <= 0 and y_valid <= 0. No accept occurs (in_ready=0). Data registers and counters are unchanged. Flush overrides any same-cycle ready drain.
- Counters wrap modulo 2^CNT_W (255 -> 0 at default). They count accepts, not deliveries.
- in_sel and in_data are don't-care when in_valid=0.

## Timing

- Latency: a word accepted at edge N is visible on x_data/x_valid after edge N. The sink may take it in cycle N+1.
- Throughput: 1 word/cycle sustained to one sink with ready held high, or alternating between sinks.
- Handshake: once asserted, x_valid/y_valid remain high until a ready-qualified transfer or a flush. The producer may change in_data/in_sel while in_ready=0.
- No combinational path from in_data to any output. The only combinational paths run from in_sel/flush/x_ready/y_ready/x_valid/y_valid to in_ready.
- Reset mid-transfer: pending words are discarded immediately on rst_n fall. On rst_n rise, the first accept is possible at the first clk edge after release.

## Test plan

- Reset: hold rst_n=0 with in_valid=1 -> in_ready=0, x_valid=y_valid=0, x_data=y_data=0, counts 0. After release, drive in_data=16'h1234, sel=0 -> x_data=16'h1234, x_valid=1 one cycle later, x_cnt=1, Y untouched.
- Back-pressure isolation: X stalled (x_ready=0) holding 16'hAAAA, then send sel=0 word 16'hBBBB -> in_ready=0, x_data stays 16'hAAAA. Switch to sel=1 word 16'h5555 -> accepted, y_data=16'h5555 while X is still stalled.
- Streaming: both readies high, send 16'h0001..16'h0008 alternating sel -> X receives 1,3,5,7 and Y receives 2,4,6,8 with no gaps and no bubbles. x_cnt=y_cnt=4.
- Same-cycle drain+load: x_valid=1 with 16'h00FF, x_ready=1, accept 16'hFF00 for X -> next cycle x_valid=1 and x_data=16'hFF00, with no valid drop.
- Flush: both sinks valid, assert flush with in_valid=1 -> in_ready=0. Next cycle both valids are 0, data and counts unchanged, and the input word is not counted.
- Counter wrap: 256 accepts to Y -> y_cnt returns to 0, and x_cnt is unaffected.
